// File: rtl/mips_pkg.sv
// Shared widths, loader state encoding and header decode for the program loader.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    INSTR,
    DATA,
    WRITE,
    DONE
  } state_t;

  // 0x00 and anything above the memory depth both mean a full image
  function automatic logic [CNT_W-1:0] clip_count(input logic [7:0] b);
    logic [CNT_W-1:0] lim;
    lim = CNT_W'(1) << ADDR_W;
    if (b == 8'd0 || CNT_W'(b) > lim)
      return lim;
    return CNT_W'(b);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, core memory write port and done flag out.
interface program_loader_if;
  import mips_pkg::*;

  logic [7:0]        inByte;
  logic              inValid;
  logic              inReady;
  logic [WORD_W-1:0] instruction;
  logic [ADDR_W-1:0] instructionAddress;
  logic [WORD_W-1:0] data;
  logic [ADDR_W-1:0] dataAddress;
  logic              writeEnable;
  logic              loadDone;

  modport master (
    input  inByte, inValid,
    output inReady, instruction, instructionAddress,
    output data, dataAddress, writeEnable, loadDone
  );

  modport slave (
    output inByte, inValid,
    input  inReady, instruction, instructionAddress,
    input  data, dataAddress, writeEnable, loadDone
  );

endinterface

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler; word shows the word that the
// current byte completes, full marks the fourth byte of a word.
module byte_packer
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              resetN,
  input  logic              clear,
  input  logic              load,
  input  logic [7:0]        din,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [1:0]        cnt;
  logic [WORD_W-9:0] acc;

  assign word = {acc, din};
  assign full = (cnt == 2'd3);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt <= '0;
      acc <= '0;
    end else if (clear) begin
      cnt <= '0;
      acc <= '0;
    end else if (load) begin
      cnt <= cnt + 2'd1;
      acc <= {acc[WORD_W-17:0], din};
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a counted image of (instruction, data) word pairs into the
// core's instruction and data memories, one shared write per record.
module program_loader
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              resetN,
  input  logic              start,
  program_loader_if.master  bus
);

  state_t            state;
  logic [ADDR_W-1:0] k;
  logic [CNT_W-1:0]  n;
  logic              rdy;
  logic              we;
  logic              done;
  logic [WORD_W-1:0] instr_q;
  logic [WORD_W-1:0] data_q;
  logic [ADDR_W-1:0] iaddr_q;
  logic [ADDR_W-1:0] daddr_q;

  logic [WORD_W-1:0] pk_word;
  logic              pk_full;
  logic              xfer;
  logic              load;
  logic              clear;
  logic              last;

  assign xfer  = bus.inValid && rdy;
  assign load  = xfer && (state == INSTR || state == DATA);
  assign clear = start && (state == IDLE || state == DONE);
  assign last  = ({1'b0, k} == n - CNT_W'(1));

  byte_packer u_pk (
    .clk    (clk),
    .resetN (resetN),
    .clear  (clear),
    .load   (load),
    .din    (bus.inByte),
    .word   (pk_word),
    .full   (pk_full)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      k       <= '0;
      n       <= '0;
      rdy     <= 1'b0;
      we      <= 1'b0;
      done    <= 1'b0;
      instr_q <= '0;
      data_q  <= '0;
      iaddr_q <= '0;
      daddr_q <= '0;
    end else begin
      we <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= HEADER;
            done  <= 1'b0;
            k     <= '0;
            rdy   <= 1'b1;
          end
        end
        HEADER: begin
          if (xfer) begin
            n     <= clip_count(bus.inByte);
            state <= INSTR;
          end
        end
        INSTR: begin
          if (xfer && pk_full) begin
            instr_q <= pk_word;
            state   <= DATA;
          end
        end
        DATA: begin
          if (xfer && pk_full) begin
            data_q  <= pk_word;
            iaddr_q <= k;
            daddr_q <= k;
            we      <= 1'b1;
            rdy     <= 1'b0;
            state   <= WRITE;
          end
        end
        WRITE: begin
          // k saturates at the final record, so address 127 never wraps
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            k     <= k + ADDR_W'(1);
            rdy   <= 1'b1;
            state <= INSTR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.inReady            = rdy;
  assign bus.writeEnable        = we;
  assign bus.loadDone           = done;
  assign bus.instruction        = instr_q;
  assign bus.data               = data_q;
  assign bus.instructionAddress = iaddr_q;
  assign bus.dataAddress        = daddr_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: driver queues expected writes,
// a negedge monitor pops and compares each writeEnable pulse.
module tb_program_loader;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic resetN;
  logic start;

  program_loader_if bus ();

  program_loader dut (
    .clk    (clk),
    .resetN (resetN),
    .start  (start),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] i;
    logic [31:0] d;
    logic [6:0]  a;
  } exp_t;

  exp_t        q[$];
  int          passed = 0;
  int          total  = 0;
  int          nwr    = 0;
  logic [6:0]  ka;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetN === 1'b1 && bus.writeEnable === 1'b1) begin
      nwr++;
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write got addr=%0h exp no write",
                 bus.instructionAddress);
      end else begin
        e = q.pop_front();
        chk("wr_instr", 64'(bus.instruction), 64'(e.i));
        chk("wr_data", 64'(bus.data), 64'(e.d));
        chk("wr_iaddr", 64'(bus.instructionAddress), 64'(e.a));
        chk("wr_daddr", 64'(bus.dataAddress), 64'(e.a));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    bus.inByte  = b;
    bus.inValid = 1'b1;
    while (bus.inReady !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      total++;
      $display("FAIL send_timeout got inReady=0 exp 1 byte=%0h", b);
    end
    @(negedge clk);
    bus.inValid = 1'b0;
  endtask

  task automatic record(input logic [31:0] iw, input logic [31:0] dw,
                        input bit gap, input bit pulse);
    q.push_back('{iw, dw, ka});
    ka = ka + 7'd1;
    for (int j = 0; j < 4; j++) begin
      send(iw[31-8*j -: 8]);
      if (gap) @(negedge clk);
    end
    for (int j = 0; j < 4; j++) begin
      if (pulse && j == 2) start = 1'b1;
      send(dw[31-8*j -: 8]);
      start = 1'b0;
      if (gap) @(negedge clk);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ka = '0;
    chk("start_rdy_done", 64'({bus.inReady, bus.loadDone}), 64'(2'b10));
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (bus.loadDone !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("loadDone", 64'(bus.loadDone), 64'd1);
    chk("sb_drained", 64'(q.size()), 64'd0);
    repeat (4) @(negedge clk);
    chk("done_hold", 64'({bus.loadDone, bus.writeEnable, bus.inReady}),
        64'(3'b100));
  endtask

  task automatic full_image(input logic [7:0] hdr);
    int w0;
    w0 = nwr;
    do_start();
    send(hdr);
    for (int i = 0; i < 128; i++)
      record(32'h1000_0000 | 32'(i), ~(32'h1000_0000 | 32'(i)), 1'b0, 1'b0);
    wait_done();
    chk("full_writes", 64'(nwr - w0), 64'd128);
    chk("full_last_addr", 64'(bus.instructionAddress), 64'd127);
  endtask

  initial begin
    resetN      = 1'b1;
    start       = 1'b0;
    bus.inValid = 1'b0;
    bus.inByte  = 8'h00;
    ka          = '0;
    #1 resetN = 1'b0;
    #2;
    chk("rst_words", 64'({bus.instruction, bus.data}), 64'd0);
    chk("rst_ctrl", 64'({bus.instructionAddress, bus.dataAddress,
        bus.writeEnable, bus.inReady, bus.loadDone}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;

    // bytes offered in IDLE must not be taken
    bus.inValid = 1'b1;
    bus.inByte  = 8'hAA;
    repeat (3) @(negedge clk);
    chk("idle_not_ready", 64'(bus.inReady), 64'd0);
    bus.inValid = 1'b0;

    do_start();
    send(8'h01);
    record(32'h2022_0003, 32'h0000_000C, 1'b0, 1'b0);
    wait_done();

    do_start();
    send(8'h03);
    record(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0);
    record(32'h8C22_0004, 32'hCAFE_F00D, 1'b1, 1'b0);
    record(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done();

    full_image(8'h00);
    full_image(8'h90);

    do_start();
    send(8'h01);
    send(8'h20);
    send(8'h22);
    send(8'h00);
    send(8'h03);
    send(8'h00);
    #2 resetN = 1'b0;
    #1;
    chk("async_words", 64'({bus.instruction, bus.data}), 64'd0);
    chk("async_ctrl", 64'({bus.instructionAddress, bus.dataAddress,
        bus.writeEnable, bus.inReady, bus.loadDone}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 64'({bus.inReady, bus.loadDone}), 64'd0);
    do_start();
    send(8'h01);
    record(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    wait_done();

    do_start();
    send(8'h02);
    record(32'hA1B2_C3D4, 32'hE5F6_0718, 1'b0, 1'b1);
    record(32'h2940_0001, 32'h0000_0055, 1'b0, 1'b0);
    wait_done();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter WORD_W, 32, width of the instruction and data words.
REQ-002 Parameter ADDR_W, 7, width of the word address into the core's instruction and data memories.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 resetN  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  begin a load; sampled in IDLE and DONE only.
REQ-006 inByte  input  8  incoming program byte.
REQ-007 inValid  input  1  inByte is valid this cycle.
REQ-008 inReady  output  1  loader accepts a byte this cycle; a transfer occurs when inValid && inReady at the rising edge.
REQ-009 instruction  output  WORD_W  instruction word to the core's instruction-memory write port.
REQ-010 instructionAddress  output  ADDR_W  instruction-memory write address.
REQ-011 data  output  WORD_W  data word to the core's data-memory write port.
REQ-012 dataAddress  output  ADDR_W  data-memory write address.
REQ-013 writeEnable  output  1  shared write strobe into both core memories.
REQ-014 loadDone  output  1  image fully written; core may run.

Function
REQ-015 States SHALL be IDLE, HEADER, INSTR, DATA, WRITE and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL move to HEADER, clear loadDone and zero the record index k.
REQ-017 inReady SHALL be 1 in HEADER, INSTR and DATA, and 0 in IDLE, WRITE and DONE.
REQ-018 HEADER: the accepted byte SHALL set record count N (0x00 means 128; 0x81-0xFF are clipped to 128), then the state SHALL move to INSTR.
REQ-019 INSTR/DATA: 4 accepted bytes SHALL assemble one word, big-endian (first byte to [31:24]); cycles without a transfer SHALL leave state and partial word unchanged.
REQ-020 After the 4th INSTR byte the state SHALL move to DATA; after the 4th DATA byte it SHALL move to WRITE.
REQ-021 WRITE: writeEnable SHALL be 1 for exactly one cycle, with instruction and data holding the assembled words and instructionAddress = dataAddress = k.
REQ-022 After WRITE: if k == N-1, the state SHALL move to DONE; otherwise k increments and the state returns to INSTR.
REQ-023 DONE: loadDone SHALL be 1 and writeEnable 0 until start.
REQ-024 All outputs SHALL be registered, with no combinational path from inValid to inReady.
REQ-025 start outside IDLE/DONE SHALL be ignored; inValid while inReady=0 SHALL be ignored and no byte consumed.
REQ-026 k SHALL never wrap: a write to address 127 followed by DONE is legal.

Reset
REQ-027 resetN low SHALL immediately force IDLE, k=0, N=0, partial word=0, and instruction=data=0, addresses=0, writeEnable=0, inReady=0, loadDone=0.
REQ-028 Reset mid-load SHALL abandon the load with no further writeEnable pulse; a new start SHALL be required.

Structure
REQ-029 WORD_W, ADDR_W and the state enumeration SHALL live in shared package mips_pkg.
REQ-030 Byte-to-word assembly SHALL be one sub-module, byte_packer: 8-bit in, load strobe, 2-bit byte counter, word-complete flag, clear.

Verification
REQ-031 Reset, start, bytes 01, 20 22 00 03, 00 00 00 0C -> one writeEnable pulse with instruction=0x20220003, data=0x0000000C, addresses=0, then loadDone=1.
REQ-032 Header 03 plus 24 bytes, inValid toggled every other cycle -> 3 pulses at addresses 0,1,2, words intact, no byte lost or duplicated.
REQ-033 Header 00 plus 1024 bytes -> 128 pulses, last at address 127, then DONE with no wrap to 0.
REQ-034 resetN low after 5 record bytes -> all outputs 0 asynchronously, no writeEnable; restart with header 01 -> write at address 0.
REQ-035 start pulsed during DATA, and inValid held high during WRITE -> no state disturbance and exactly 8 bytes consumed per record.
REQ-036 start in DONE -> loadDone cleared, k=0, next header accepted.
